// File: rtl/generador_verificador_capa_if.sv
// generador_verificador_capa_if: FIFO-side bus of the traffic generator/checker
// master (generator/checker): drives fifo_in/push to the main FIFO and pop_ch to the
// per-channel output FIFOs; samples almost_full, empty_ch and data_ch (1-cycle read latency).
// slave (FIFO fabric / bench model): the mirror image.
interface generador_verificador_capa_if #(
  parameter int DATA_W = 12,
  parameter int N_CH   = 4
);
  logic                   almost_full;
  logic [DATA_W-1:0]      fifo_in;
  logic                   push;
  logic [N_CH-1:0]        empty_ch;
  logic [N_CH*DATA_W-1:0] data_ch;
  logic [N_CH-1:0]        pop_ch;
  modport master (input almost_full, empty_ch, data_ch, output fifo_in, push, pop_ch);
  modport slave  (output almost_full, empty_ch, data_ch, input fifo_in, push, pop_ch);
endinterface

// File: rtl/generador_verificador_capa.sv
// generador_verificador_capa: pushes tagged bursts into a switch fabric and checks what drains out
// Ports: clk, reset (async, active-high); start/ch_mask launch a run; fifo bus (master modport)
// carries push side and per-channel pop side; busy/done/error/err_ch/timeout/sent_cnt/recv_cnt
// report run status. Word format is {dest, seq}, seq restarting at 0 for every run.
module generador_verificador_capa #(
  parameter int DATA_W = 12,
  parameter int N_CH   = 4,
  parameter int CH_W   = 2,
  parameter int BURST  = 6,
  parameter int TMO    = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [N_CH-1:0]     ch_mask,
  generador_verificador_capa_if.master fifo,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [CH_W-1:0]     err_ch,
  output logic                timeout,
  output logic [7:0]          sent_cnt,
  output logic [7:0]          recv_cnt
);
  localparam int SEQ_W = DATA_W - CH_W;
  localparam int TW    = $clog2(TMO + 1);
  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
  state_t            state;
  logic [N_CH-1:0]   mask_r, pend, bad;
  logic [CH_W-1:0]   cur_ch, nxt_ch, first_ch, err_idx;
  logic              last_ch;
  logic [5:0]        word_cnt;
  logic [SEQ_W-1:0]  exp_seq [N_CH];
  logic [TW-1:0]     idle_cnt;
  logic [CH_W:0]     n_chk;
  logic [8:0]        recv_sum;
  logic [DATA_W-1:0] word;
  assign busy          = state != IDLE;
  // push is gated combinationally so it never coincides with almost_full
  assign fifo.push     = state == GEN && !fifo.almost_full;
  assign fifo.fifo_in  = state == GEN ? {cur_ch, SEQ_W'(word_cnt)} : '0;
  assign fifo.pop_ch   = busy ? ~fifo.empty_ch : '0;
  assign recv_sum      = {1'b0, recv_cnt} + 9'(n_chk);
  always_comb begin
    bad      = '0;
    n_chk    = '0;
    word     = '0;
    err_idx  = '0;
    nxt_ch   = cur_ch;
    last_ch  = 1'b1;
    first_ch = '0;
    // pend[i] marks data_ch[i] as valid: popped on the previous cycle
    for (int i = 0; i < N_CH; i++) begin
      word = fifo.data_ch[i*DATA_W +: DATA_W];
      if (pend[i]) begin
        n_chk  = n_chk + (CH_W+1)'(1);
        bad[i] = !mask_r[i] || word[DATA_W-1 -: CH_W] != CH_W'(i) || word[SEQ_W-1:0] != exp_seq[i];
      end
    end
    // descending scans leave the lowest qualifying index
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (bad[i]) err_idx = CH_W'(i);
      if (ch_mask[i]) first_ch = CH_W'(i);
      if (mask_r[i] && CH_W'(i) > cur_ch) begin
        nxt_ch  = CH_W'(i);
        last_ch = 1'b0;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mask_r   <= '0;
      pend     <= '0;
      cur_ch   <= '0;
      word_cnt <= '0;
      idle_cnt <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_ch   <= '0;
      timeout  <= 1'b0;
      sent_cnt <= '0;
      recv_cnt <= '0;
      for (int i = 0; i < N_CH; i++) exp_seq[i] <= '0;
    end else begin
      done <= 1'b0;
      pend <= fifo.pop_ch;
      for (int i = 0; i < N_CH; i++) if (pend[i]) exp_seq[i] <= exp_seq[i] + SEQ_W'(1);
      recv_cnt <= recv_sum[8] ? 8'hFF : recv_sum[7:0];
      if (|bad && !error) begin
        error  <= 1'b1;
        err_ch <= err_idx;
      end
      case (state)
        IDLE: if (start) begin
          if (|ch_mask) begin
            state    <= GEN;
            mask_r   <= ch_mask;
            cur_ch   <= first_ch;
            word_cnt <= '0;
            idle_cnt <= '0;
            sent_cnt <= '0;
            recv_cnt <= '0;
            error    <= 1'b0;
            err_ch   <= '0;
            timeout  <= 1'b0;
            for (int i = 0; i < N_CH; i++) exp_seq[i] <= '0;
          end else done <= 1'b1;
        end
        GEN: if (fifo.push) begin
          sent_cnt <= sent_cnt == 8'hFF ? 8'hFF : sent_cnt + 8'd1;
          if (word_cnt == 6'(BURST - 1)) begin
            word_cnt <= '0;
            cur_ch   <= nxt_ch;
            if (last_ch) state <= DRAIN;
          end else word_cnt <= word_cnt + 6'd1;
        end
        DRAIN: begin
          if (recv_cnt == sent_cnt) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (n_chk != '0) idle_cnt <= '0;
          else if (idle_cnt == TW'(TMO - 1)) begin
            error   <= 1'b1;
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= IDLE;
          end else idle_cnt <= idle_cnt + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_generador_verificador_capa.sv
// tb_generador_verificador_capa: directed runs against a loopback FIFO model with fault injection
module tb_generador_verificador_capa;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  ch_mask;
  logic        busy, done, error, timeout;
  logic [1:0]  err_ch;
  logic [7:0]  sent_cnt, recv_cnt;
  int          n_vec = 0, n_bad = 0;
  generador_verificador_capa_if #(.DATA_W(12), .N_CH(4)) fifo ();
  generador_verificador_capa dut (
    .clk(clk), .reset(reset), .start(start), .ch_mask(ch_mask), .fifo(fifo),
    .busy(busy), .done(done), .error(error), .err_ch(err_ch), .timeout(timeout),
    .sent_cnt(sent_cnt), .recv_cnt(recv_cnt)
  );
  always #5 clk = ~clk;
  logic [11:0] q [4][$];
  logic [11:0] data_r [4];
  logic [3:0]  empty_r;
  logic [11:0] push_log [$];
  int          af_viol = 0;
  bit          corrupt_en = 0, drop_en = 0, stray = 0;
  logic [11:0] corrupt_from, corrupt_to, drop_word;
  assign fifo.empty_ch = empty_r;
  assign fifo.data_ch  = {data_r[3], data_r[2], data_r[1], data_r[0]};
  always @(posedge clk or posedge reset) begin
    logic [11:0] w;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        q[i].delete();
        data_r[i] <= '0;
      end
      empty_r <= '1;
    end else begin
      for (int i = 0; i < 4; i++)
        if (fifo.pop_ch[i] && q[i].size() > 0) begin
          w = q[i].pop_front();
          data_r[i] <= w;
        end
      if (fifo.push) begin
        w = fifo.fifo_in;
        push_log.push_back(w);
        if (fifo.almost_full) af_viol++;
        if (!(drop_en && w == drop_word)) q[w[11:10]].push_back(corrupt_en && w == corrupt_from ? corrupt_to : w);
      end
      if (stray) q[3].push_back(12'hC00);
      for (int i = 0; i < 4; i++) empty_r[i] <= q[i].size() == 0;
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic kick(input logic [3:0] m, output int idx);
    @(negedge clk);
    idx = push_log.size();
    ch_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, done, 1);
  endtask
  task automatic check_log(input string tag, input int idx, input logic [3:0] m);
    int errs = 0, k = idx;
    for (int c = 0; c < 4; c++)
      if (m[c])
        for (int s = 0; s < 6; s++) begin
          if (k >= push_log.size() || push_log[k] != 12'((c << 10) | s)) errs++;
          k++;
        end
    if (push_log.size() != k) errs++;
    check({tag, "_log"}, errs, 0);
  endtask
  initial begin
    int idx, acc;
    reset = 1'b1; start = 1'b0; ch_mask = '0; fifo.almost_full = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_cnts", {sent_cnt, recv_cnt}, 0);
    check("rst_err", {error, timeout, err_ch}, 0);
    check("rst_bus", {fifo.push, fifo.pop_ch, fifo.fifo_in}, 0);
    reset = 1'b0;
    @(negedge clk);
    ch_mask = 4'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mask0_done", done, 1);
    check("mask0_busy", busy, 0);
    // ideal loopback, plus a start pulse while busy that must be ignored
    kick(4'hF, idx);
    repeat (3) @(negedge clk);
    ch_mask = 4'h1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ideal");
    check("ideal_cnts", {sent_cnt, recv_cnt}, {8'd24, 8'd24});
    check("ideal_err", {error, timeout}, 0);
    check_log("ideal", idx, 4'hF);
    @(negedge clk);
    check("ideal_idle", {busy, done}, 0);
    // back-pressure mid-GEN
    kick(4'hF, idx);
    repeat (6) @(negedge clk);
    fifo.almost_full = 1'b1;
    repeat (5) @(negedge clk);
    fifo.almost_full = 1'b0;
    wait_done("af");
    check("af_viol", af_viol, 0);
    check("af_cnts", {sent_cnt, recv_cnt}, {8'd24, 8'd24});
    check("af_err", error, 0);
    check_log("af", idx, 4'hF);
    // corrupted word on channel 2
    corrupt_en = 1; corrupt_from = 12'h802; corrupt_to = 12'h803;
    kick(4'hF, idx);
    wait_done("corrupt");
    corrupt_en = 0;
    check("corrupt_err", {error, timeout, err_ch}, {1'b1, 1'b0, 2'd2});
    check("corrupt_cnts", {sent_cnt, recv_cnt}, {8'd24, 8'd24});
    // lost channel-1 word -> drain timeout
    drop_en = 1; drop_word = 12'h405;
    kick(4'hF, idx);
    wait_done("drop");
    drop_en = 0;
    check("drop_err", {error, timeout}, 2'b11);
    check("drop_cnts", {sent_cnt, recv_cnt}, {8'd24, 8'd23});
    // partial mask with a stray word on disabled channel 3
    kick(4'b0101, idx);
    stray = 1;
    @(negedge clk);
    stray = 0;
    wait_done("mask5");
    check("mask5_sent", sent_cnt, 12);
    check("mask5_err", {error, err_ch}, {1'b1, 2'd3});
    check_log("mask5", idx, 4'b0101);
    // reset during DRAIN
    kick(4'hF, idx);
    acc = 0;
    while (sent_cnt != 8'd24 && acc < 200) begin
      @(negedge clk);
      acc++;
    end
    check("drain_reached", {busy, sent_cnt}, {1'b1, 8'd24});
    #2 reset = 1'b1;
    #1;
    check("mid_rst_state", {busy, done, error, timeout, err_ch}, 0);
    check("mid_rst_cnts", {sent_cnt, recv_cnt}, 0);
    check("mid_rst_bus", {fifo.push, fifo.pop_ch, fifo.fifo_in}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    acc = 0;
    repeat (5) begin
      @(negedge clk);
      acc = acc | int'(fifo.push) | int'(|fifo.pop_ch) | int'(busy);
    end
    check("post_rst_quiet", acc, 0);
    kick(4'hF, idx);
    wait_done("rerun");
    check("rerun_cnts", {sent_cnt, recv_cnt}, {8'd24, 8'd24});
    check("rerun_err", {error, timeout}, 0);
    check_log("rerun", idx, 4'hF);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
